// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t  : FSM state encoding (IDLE / RUN / DONE, 2 bits)
//   SA_WIDTH : default operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SA_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder cell.
//   a, b, c_in : addend bits and carry-in
//   sum, c_out : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  always_comb begin
    sum   = a ^ b ^ c_in;
    c_out = (a & b) | (c_in & (a ^ b));
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: captures a, b, c_in on an accepted start,
// then feeds one bit per clock (LSB first) through a single full_adder.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin an addition (sampled only while idle)
//   a, b, c_in : operands and carry-in, captured on the accepted start edge
//   sum, c_out : registered result, held until the next completion
//   busy       : high whenever an operation is in flight (RUN or DONE)
//   done       : one-cycle pulse when sum/c_out first show a new result
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy,
  output logic             done
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  // Only the upper WIDTH-1 partial-sum bits are kept; the final bit comes
  // straight from the slice on the completing edge.
  logic [WIDTH-2:0]   sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_sum;
  logic               fa_c_out;
  logic               last;
  logic [WIDTH-1:0]   sum_nxt;

  full_adder u_slice (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_c_out)
  );

  always_comb begin
    last    = (cnt == CNT_LAST);
    sum_nxt = {fa_sum, sum_sh};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE:            state_nxt = ST_IDLE;
      default:            state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; done is high only during the single DONE cycle
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Datapath: shift registers, carry, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      c_out  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= c_in;
            cnt    <= '0;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nxt[WIDTH-1:1];
          carry  <= fa_c_out;
          if (last) begin
            sum   <= sum_nxt;
            c_out <= fa_c_out;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // advance one clock; outputs are then sampled 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: full-width arithmetic sum
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  // waits (bounded) for done; cycles counts edges since call
  task automatic wait_done(output int cycles, output bit timed_out);
    cycles = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 4 * W; i++) begin
      step();
      cycles++;
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h11;
    b     = 8'h22;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({sum, c_out, busy, done} !== {{W{1'b0}}, 3'b000}) begin
        n_err++;
        $display("FAIL reset[%0d]: sum=%h c_out=%b busy=%b done=%b, required all zero",
                 i, sum, c_out, busy, done);
      end
    end
    start = 1'b0;
    rst   = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] held;
    a = 8'h35; b = 8'h4A; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    held = sum;
    for (int i = 1; i < W; i++) begin
      step();
      n_cmp++;
      if (done !== 1'b0 || sum !== held) begin
        n_err++;
        $display("FAIL basic_run[%0d]: done=%b sum=%h, required done=0 sum=%h",
                 i, done, sum, held);
      end
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || sum !== 8'h7F || c_out !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result: done=%b sum=%h c_out=%b, required 1 7f 0", done, sum, c_out);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h7F) begin
      n_err++;
      $display("FAIL basic_after: done=%b busy=%b sum=%h, required 0 0 7f", done, busy, sum);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] ta [2] = '{8'hFF, 8'hFF};
    logic [W-1:0] tb [2] = '{8'h01, 8'hFF};
    logic         tc [2] = '{1'b0, 1'b1};
    logic [W:0]   req [2] = '{9'h100, 9'h1FF};
    int cyc;
    bit to;
    for (int k = 0; k < 2; k++) begin
      a = ta[k]; b = tb[k]; c_in = tc[k]; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(cyc, to);
      n_cmp++;
      if (to || cyc != W || {c_out, sum} !== req[k]) begin
        n_err++;
        $display("FAIL carry[%0d]: timeout=%0d latency=%0d result=%h, required latency=%0d result=%h",
                 k, to, cyc, {c_out, sum}, W, req[k]);
      end
      step();
    end
  endtask

  task automatic test_busy();
    int dones = 0;
    a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= W + 4; i++) begin
      if (i == 3) begin
        a = 8'hAA; b = 8'h55; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 1 || sum !== 8'h30 || c_out !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_protect: dones=%0d sum=%h c_out=%b busy=%b, required 1 30 0 0",
               dones, sum, c_out, busy);
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    int cyc;
    bit to;
    a = 8'h0F; b = 8'h0F; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({sum, c_out, busy, done} !== {{W{1'b0}}, 3'b000}) begin
      n_err++;
      $display("FAIL abort_clear: sum=%h c_out=%b busy=%b done=%b, required all zero",
               sum, c_out, busy, done);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL abort_quiet: activity cycles=%0d required 0", dones);
    end
    a = 8'h01; b = 8'h02; c_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc, to);
    n_cmp++;
    if (to || cyc != W || sum !== 8'h04 || c_out !== 1'b0) begin
      n_err++;
      $display("FAIL abort_restart: timeout=%0d latency=%0d sum=%h c_out=%b, required 0 %0d 04 0",
               to, cyc, sum, c_out, W);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int period = W + 2;
    a = 8'h80; b = 8'h80; c_in = 1'b0; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic exp_done, exp_busy;
      step();
      exp_done = ((i % period) == W);
      exp_busy = ((i % period) != W + 1);
      n_cmp++;
      if (done !== exp_done || busy !== exp_busy) begin
        n_err++;
        $display("FAIL b2b_timing[%0d]: done=%b busy=%b, required %b %b",
                 i, done, busy, exp_done, exp_busy);
      end
      if (exp_done) begin
        n_cmp++;
        if (sum !== 8'h00 || c_out !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_result[%0d]: sum=%h c_out=%b, required 00 1", i, sum, c_out);
        end
      end
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   req;
    int cyc;
    bit to;
    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      req = ref_add(ra, rb, rc);
      a = ra; b = rb; c_in = rc; start = 1'b1;
      step();
      start = 1'b0;
      // operand changes after the load edge must be ignored
      a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      wait_done(cyc, to);
      n_cmp++;
      if (to || cyc != W || {c_out, sum} !== req) begin
        n_err++;
        $display("FAIL random[%0d]: %h+%h+%b timeout=%0d latency=%0d result=%h, required latency=%0d result=%h",
                 k, ra, rb, rc, to, cyc, {c_out, sum}, W, req);
      end
      repeat ($urandom_range(1, 3)) step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_busy();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
